multdiv_unit: RTL and testbench

//  Multi-cycle signed 32-bit multiply/divide unit. Complements the single-cycle combinational ALU.
//  The execute stage issues a one-cycle start pulse, stalls on busy, and reads the result when data_resultRDY pulses.

---
 rtl/multdiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed multiply (radix-2 Booth) / divide (restoring)
// unit. The result and its exception flag appear 33 cycles after a start pulse.
// Optional feature: define MULTDIV_REMAINDER_EN to add the data_remainder
// output, which carries the signed remainder (sign follows the dividend).
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef MULTDIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  // acc_q is the Booth accumulator (one guard bit so subtracting the most
  // negative multiplicand cannot overflow) and the restoring-divide remainder.
  logic [WIDTH:0]   acc_q;
  // q_q holds the multiplier (then the product low half) or the dividend
  // magnitude that is shifted out while quotient bits are shifted in.
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [WIDTH-1:0] b_q;
  logic             neg_q_q;
  logic             divz_q;
  logic             dovf_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
`ifdef MULTDIV_REMAINDER_EN
  logic             neg_r_q;
  logic [WIDTH-1:0] rem_q;
`endif

  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last_step;

  assign last_step      = (cnt_q == CNT_W'(ITERS));
  assign data_result    = result_q;
  assign data_exception = exc_q;
`ifdef MULTDIV_REMAINDER_EN
  assign data_remainder = rem_q;
`endif

  // Magnitudes for the divider; the most negative value maps to unsigned 2^(WIDTH-1).
  always_comb begin
    abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  end

  // Booth add/subtract selection and the restoring-divide trial subtraction.
  always_comb begin
    b_ext     = {b_q[WIDTH-1], b_q};
    booth_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + b_ext;
      2'b10:   booth_sum = acc_q - b_ext;
      default: booth_sum = acc_q;
    endcase
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and status outputs; MULT has priority over DIV.
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_MULT)     state_d = MULT;
        else if (ctrl_DIV) state_d = DIV;
      end
      MULT, DIV: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, one iteration per cycle, then the final fix-up.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      b_q      <= '0;
      neg_q_q  <= 1'b0;
      divz_q   <= 1'b0;
      dovf_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      neg_r_q  <= 1'b0;
      rem_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          acc_q <= '0;
          qm1_q <= 1'b0;
          if (ctrl_MULT) begin
            q_q <= data_operandA;
            b_q <= data_operandB;
          end else if (ctrl_DIV) begin
            q_q     <= abs_a;
            b_q     <= abs_b;
            neg_q_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divz_q  <= (data_operandB == '0);
            dovf_q  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
`ifdef MULTDIV_REMAINDER_EN
            neg_r_q <= data_operandA[WIDTH-1];
`endif
          end
        end
        MULT: begin
          if (!last_step) begin
            acc_q <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_q   <= {booth_sum[0], q_q[WIDTH-1:1]};
            qm1_q <= q_q[0];
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= q_q;
            exc_q    <= (acc_q[WIDTH-1:0] != {WIDTH{q_q[WIDTH-1]}});
`ifdef MULTDIV_REMAINDER_EN
            rem_q    <= '0;
`endif
          end
        end
        DIV: begin
          if (!last_step) begin
            if (div_diff[WIDTH]) begin
              acc_q <= div_shift;
              q_q   <= {q_q[WIDTH-2:0], 1'b0};
            end else begin
              acc_q <= div_diff;
              q_q   <= {q_q[WIDTH-2:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (divz_q) begin
            result_q <= '0;
            exc_q    <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            rem_q    <= '0;
`endif
          end else if (dovf_q) begin
            result_q <= MIN_NEG;
            exc_q    <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            rem_q    <= '0;
`endif
          end else begin
            result_q <= neg_q_q ? (~q_q + 1'b1) : q_q;
            exc_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            rem_q    <= neg_r_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit. Expected results are
// computed with native signed arithmetic when a start is driven and compared
// when the DUT pulses data_resultRDY. Define MULTDIV_REMAINDER_EN to also
// check data_remainder.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef MULTDIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          start;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model from native signed arithmetic.
  task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output logic [31:0] rm);
    longint p;
    int     sa, sb_v;
    sa   = $signed(a);
    sb_v = $signed(b);
    rm   = '0;
    if (m) begin
      p = longint'(sa) * longint'(sb_v);
      r = p[31:0];
      e = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r  = sa / sb_v;
      rm = sa % sb_v;
      e  = 1'b0;
    end
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        $display("RDY without a pending operation: result=%h", data_result);
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("%-10s result=%h exc=%0b latency=%0d", mon_e.name, data_result,
                 data_exception, cyc - mon_e.start);
        check({mon_e.name, "_res"}, 64'(data_result), 64'(mon_e.res));
        check({mon_e.name, "_exc"}, 64'(data_exception), 64'(mon_e.exc));
        check({mon_e.name, "_lat"}, 64'(cyc - mon_e.start), 64'd33);
`ifdef MULTDIV_REMAINDER_EN
        check({mon_e.name, "_rem"}, 64'(data_remainder), 64'(mon_e.rem));
`endif
      end
    end
  end

  // Drive one start cycle; optionally record the expected outcome.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input bit push, input string name);
    exp_t e;
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    if (push) begin
      model(m, a, b, e.res, e.exc, e.rem);
      e.start = cyc;
      e.name  = name;
      sb.push_back(e);
    end
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check("rdy_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!data_resultRDY && n < 60);
    if (!data_resultRDY) check("rdy_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input bit m, input logic [31:0] a, input logic [31:0] b, input string name);
    start_op(m, !m, a, b, 1'b1, name);
    wait_idle();
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'd0);
`ifdef MULTDIV_REMAINDER_EN
    check("reset_rem", 64'(data_remainder), 64'd0);
`endif
    reset_n = 1'b1;

    // 1: multiply with busy profile around the 33-cycle window.
    start_op(1'b1, 1'b0, 32'd7, -32'sd3, 1'b1, "mul7x-3");
    check("busy_first", 64'(busy), 64'd1);
    repeat (33) @(negedge clock);
    check("busy_last", 64'(busy), 64'd1);
    @(negedge clock);
    check("busy_drop", 64'(busy), 64'd0);
    check("rdy_at_33", 64'(data_resultRDY), 64'd1);
    wait_idle();

    // 2: multiply overflow, then largest positive product that fits.
    run(1'b1, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    run(1'b1, 32'h7FFF_FFFF, 32'd1, "mul_max");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "mul_minx-1");

    // 3: divide cases including divide-by-zero and overflow.
    run(1'b0, -32'sd7, 32'd2, "div-7/2");
    run(1'b0, 32'd100, 32'd0, "div_by0");
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(1'b0, 32'h8000_0000, 32'd3, "div_min/3");
    run(1'b0, 32'd45, -32'sd7, "div45/-7");

    // 4: starts while busy and in the RDY cycle are ignored.
    start_op(1'b0, 1'b1, 32'd50, 32'd5, 1'b1, "div50/5");
    repeat (8) @(posedge clock);
    start_op(1'b1, 1'b0, 32'd6, 32'd6, 1'b0, "ignored");
    wait_rdy();
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    repeat (3) @(negedge clock);
    check("busy_after_ignored", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    check("result_held", 64'(data_result), 64'd10);

    // 5: reset aborts an in-flight multiply.
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b1, "mul3x4");
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clock);
    check("abort_outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'd0);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_busy", 64'(busy), 64'd0);
    run(1'b0, 32'd9, 32'd3, "div9/3");

    // 6: back-to-back; the first result holds until the second RDY.
    start_op(1'b1, 1'b0, 32'd2, 32'd5, 1'b1, "mul2x5");
    wait_idle();
    start_op(1'b0, 1'b1, -32'sd9, 32'd4, 1'b1, "div-9/4");
    repeat (20) @(negedge clock);
    check("hold_res", 64'(data_result), 64'd10);
    check("hold_exc", 64'(data_exception), 64'd0);
    wait_idle();

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 1) ? $urandom_range(1, 1000) : $urandom;
      if (i % 3 == 0) b = -b;
      run(i % 2 == 0, a, b, (i % 2 == 0) ? "rnd_mul" : "rnd_div");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
